// File: rtl/rcvr_pkg.sv
// Shared constants and state encoding for the serial packet link (xmt_sched transmitter, rcvr receiver).
package rcvr_pkg;

  localparam logic [7:0] HEAD_BYTE = 8'hA5;
  localparam int         BODY_BITS = 8;
  localparam int         PKT_BITS  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP_ST = 2'd2
  } xmt_state_e;

  function automatic logic even_parity(input logic [BODY_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/xmt_sched_if.sv
// Requester/scheduler bundle for xmt_sched, plus the serial line and status outputs.
interface xmt_sched_if #(
    parameter int NREQ = 4
);
    import rcvr_pkg::*;

    // Handshake: req[k] is a level held with stable data_in byte k until grant[k]
    // pulses for one cycle; the byte is captured on that cycle and req[k] may drop
    // afterwards. A req still high after its grant counts as a new request.
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] data_in;
    logic [NREQ-1:0]   grant;
    logic              data_out;
    logic              busy;
    logic [2:0]        owner;
    xmt_state_e        state_dbg;

    modport master (output req, data_in, input grant, data_out, busy, owner, state_dbg);
    modport slave  (input req, data_in, output grant, data_out, busy, owner, state_dbg);

endinterface

// File: rtl/xmt_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            any
);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = 3'(k);
            end
        end
    end

endmodule

// File: rtl/xmt_sched.sv
// Round-robin transmit scheduler framing {0xA5, byte} MSB first onto one serial line.
// Optional XMT_PARITY_EN appends an even-parity bit over the body byte.
module xmt_sched
    import rcvr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GAP  = 0
) (
    input  logic         clock,
    input  logic         reset,
    xmt_sched_if.slave   bus
);

`ifdef XMT_PARITY_EN
    localparam int PKT_LEN = PKT_BITS + 1;
`else
    localparam int PKT_LEN = PKT_BITS;
`endif
    // The first header bit goes straight to data_out; the shifter holds the rest.
    localparam int         SH_W     = PKT_LEN - 1;
    localparam logic [4:0] LAST_BIT = 5'(PKT_LEN - 1);
    localparam logic [4:0] GAP_LAST = 5'((GAP > 0) ? GAP - 1 : 0);

    xmt_state_e      state, state_n;
    logic [4:0]      bit_cnt, cnt_n;
    logic [SH_W-1:0] shreg, shreg_n;
    logic            data_q, data_n;
    logic            busy_q, busy_n;
    logic [NREQ-1:0] grant_q, grant_n;
    logic [2:0]      owner_q, owner_n;
    logic [2:0]      ptr_q, ptr_n;

    logic [NREQ-1:0] arb_gnt;
    logic [2:0]      arb_idx;
    logic            arb_any;
    logic            arb_en;
    logic [7:0]      win_byte;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign win_byte = bus.data_in[int'(arb_idx)*8 +: 8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            grant_q <= grant_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shreg_n = shreg;
        data_n  = data_q;
        busy_n  = busy_q;
        grant_n = '0;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        arb_en  = 1'b0;

        case (state)
            IDLE: arb_en = 1'b1;
            SEND: begin
                if (bit_cnt == LAST_BIT) begin
                    // With no gap the end-of-packet edge doubles as an arbitration edge.
                    if (GAP == 0) begin
                        arb_en = 1'b1;
                    end else begin
                        state_n = GAP_ST;
                        cnt_n   = '0;
                        data_n  = 1'b0;
                        busy_n  = 1'b1;
                    end
                end else begin
                    data_n  = shreg[SH_W-1];
                    shreg_n = {shreg[SH_W-2:0], 1'b0};
                    cnt_n   = bit_cnt + 5'd1;
                end
            end
            GAP_ST: begin
                if (bit_cnt == GAP_LAST) arb_en = 1'b1;
                else                     cnt_n  = bit_cnt + 5'd1;
            end
            default: arb_en = 1'b1;
        endcase

        if (arb_en) begin
            if (arb_any) begin
                state_n = SEND;
                cnt_n   = '0;
`ifdef XMT_PARITY_EN
                shreg_n = {HEAD_BYTE[6:0], win_byte, even_parity(win_byte)};
`else
                shreg_n = {HEAD_BYTE[6:0], win_byte};
`endif
                data_n  = HEAD_BYTE[7];
                busy_n  = 1'b1;
                grant_n = arb_gnt;
                owner_n = arb_idx;
                ptr_n   = (arb_idx == 3'(NREQ - 1)) ? 3'd0 : arb_idx + 3'd1;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
                data_n  = 1'b0;
                busy_n  = 1'b0;
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.data_out  = data_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.state_dbg = state;

endmodule

// File: doc/xmt_sched.md
Name: xmt_sched

Overview:
- Transmit-side scheduler for the serial packet link decoded by rcvr.
- Shares one serial data line between NREQ byte-wide requesters using round-robin arbitration.
- Frames each granted byte as an 8-bit header followed by an 8-bit body, both MSB first, one bit per clock.
- Output drives rcvr data_in directly (same clock domain).

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP, 0, minimum idle bit-cycles (data_out=0) inserted after each packet (0..15).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester send request; level, held until granted.
- data_in  input  NREQ*8  requester bytes; byte k = data_in[8k+7:8k]; must be stable while req[k]=1.
- grant  output  NREQ  one-hot, one-cycle pulse; byte k latched on this cycle.
- data_out  output  1  serial line to receiver.
- busy  output  1  high while a packet or gap is in progress.
- owner  output  3  index of the current/last granted requester.

Behaviour:
- Reset (async) values: grant=0, data_out=0, busy=0, owner=0, RR pointer=0, state=IDLE, bit counter=0. Reset mid-packet aborts it; the line returns to 0 immediately.
- States: IDLE, SEND (16 bit-cycles, or 17 with parity), GAP (GAP cycles).
- IDLE: at a rising edge with any req bit set, the winner is the first set req at or above the pointer, wrapping modulo NREQ.
- Registered effects of that edge: grant[w]=1 (one cycle only), owner=w, pointer=(w+1) mod NREQ, shift register={HEAD_BYTE, byte w}, data_out=HEAD_BYTE[7], busy=1, state=SEND.
- Latency: req sampled at edge N; grant and first header bit visible after edge N; last body bit visible after edge N+15.
- SEND: each edge shifts the next bit onto data_out. After the final bit:
  - GAP>0: enter GAP with data_out=0 and busy=1; return to IDLE after GAP cycles with busy=0.
  - GAP=0: arbitrate on that same edge. A pending req starts the next header bit with no idle cycle and busy stays 1; otherwise go to IDLE with data_out=0 and busy=0.
- req is ignored outside arbitration edges. A req dropped before its grant is withdrawn with no side effect. A req still high after grant is a new request; rotation prevents starvation.
- Multiple simultaneous reqs: exactly one grant; the others wait, each served within NREQ packets.
- data_in changes after the grant cycle do not affect the packet in flight.
- IDLE line level is 0. The header 0xA5 begins with 1, which marks the packet start.

Optional Feature:
- XMT_PARITY_EN defined:
  - SEND is 17 bit-cycles; bit 17 is the even parity (XOR) of the 8 body bits.
  - GAP and arbitration timing shift by one cycle.
  - Only for use with a parity-checking receiver.
- XMT_PARITY_EN undefined: exactly 16 bit-cycles, no parity logic present.

Decomposition:
- Shared package rcvr_pkg holds:
  - HEAD_BYTE = 8'hA5
  - BODY_BITS = 8
  - PKT_BITS = 16
  - state encoding constants IDLE/SEND/GAP
- rcvr can reuse HEAD_BYTE from rcvr_pkg.
- One sub-module: rr_arbiter (req vector, pointer in; one-hot grant and index out; purely combinational). The FSM and shifter stay in xmt_sched.

Test Plan:
- Single request: req[2]=1, byte 8'h49. Expect:
  - grant[2] for one cycle, owner=2
  - data_out = 1010_0101 then 0100_1001 over 16 cycles
  - busy low after the last bit
  - rcvr (HEAD 0xA5) reports data_out=0x49 ("I")
- Contention: req=4'b1111 held, bytes "L","o","v","e". Expect:
  - grants in order 0,1,2,3,0 with pointer wrap
  - back-to-back packets with no idle cycle (GAP=0)
  - rcvr receives "Love" in order
- GAP=3: two queued requests. Expect exactly 3 cycles of data_out=0 and busy=1 between the last body bit and the next header 1.
- Withdrawal: raise req[1] mid-packet, drop it before the packet ends. Expect no grant[1], busy falls after the current packet, and the line stays 0.
- Reset mid-packet: assert reset at header bit 5. Expect data_out=0, busy=0, grant=0 immediately. After release, req[3] wins even with pointer history, since the pointer is reset to 0 and only req[3] is pending.
- With XMT_PARITY_EN: byte 8'h07. Expect a 17th bit of 1 and busy held for 17 cycles.
